// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the IF/DM memory port arbiter
package mem_port_arbiter_pkg;

  // Arbiter FSM: nothing presented, presented but not yet granted, granted and awaiting response
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  // Requester that currently owns the memory port
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } mem_owner_t;

  // Width of a counter that must hold values 0..max_consec inclusive
  function automatic int cnt_width(input int max_consec);
    return (max_consec < 1) ? 1 : $clog2(max_consec + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DM_MAX_CONSEC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // instruction fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // data memory port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  // shared memory interface
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  // status
  output logic                busy
);

  localparam int               BE_W    = DATA_W / 8;
  localparam int               CNT_W   = cnt_width(DM_MAX_CONSEC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DM_MAX_CONSEC);

  arb_state_t       state_q, state_d;
  mem_owner_t       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;

  mem_owner_t       sel_owner;
  logic             issue;
  logic             in_wait;
  logic             fetch_pending;

  // Pick the requester driving the memory port this cycle; owner is locked once presented
  always_comb begin
    sel_owner = owner_q;
    issue     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        issue = if_req | dm_req;
        // DM has priority unless IF has already been passed over DM_MAX_CONSEC times
        if (dm_req && !(if_req && (cnt_q == CNT_MAX))) begin
          sel_owner = OWNER_DM;
        end else begin
          sel_owner = OWNER_IF;
        end
      end
      ARB_REQ: begin
        issue = 1'b1;
      end
      default: begin
        issue = 1'b0;
      end
    endcase
  end

  // Route the selected requester onto the memory bus; fields are zero when nothing is presented
  always_comb begin
    mem_req   = issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (issue) begin
      if (sel_owner == OWNER_DM) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_be    = dm_be;
        mem_wdata = dm_wdata;
      end else begin
        // fetches are always full-word reads
        mem_addr  = if_addr;
        mem_be    = {BE_W{1'b1}};
      end
    end
  end

  // Grants follow mem_gnt combinationally; responses go to the locked owner only
  always_comb begin
    in_wait   = (state_q == ARB_WAIT);
    if_gnt    = issue & mem_gnt & (sel_owner == OWNER_IF);
    dm_gnt    = issue & mem_gnt & (sel_owner == OWNER_DM);
    if_rvalid = in_wait & mem_rvalid & (owner_q == OWNER_IF) & ~drop_q;
    dm_rvalid = in_wait & mem_rvalid & (owner_q == OWNER_DM);
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
    busy      = (state_q != ARB_IDLE);
  end

  // Next-state logic for the arbiter FSM and the owner lock
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (issue) begin
          owner_d = sel_owner;
          state_d = mem_gnt ? ARB_WAIT : ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (mem_gnt) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Fairness counter: counts DM grants that bypassed a waiting fetch, saturating at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_gnt) begin
      cnt_d = '0;
    end else if (dm_gnt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Drop flag: a flush marks the in-flight or just-granted fetch so its response is swallowed
  always_comb begin
    fetch_pending = ((state_q == ARB_REQ) || (state_q == ARB_WAIT)) && (owner_q == OWNER_IF);
    drop_d        = drop_q;
    if (in_wait && mem_rvalid) begin
      drop_d = 1'b0;
    end else if (if_flush && (fetch_pending || if_gnt)) begin
      drop_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_IF;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Owner must keep requesting until granted
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ARB_REQ) |-> ((owner_q == OWNER_IF) ? if_req : dm_req))
    else $error("mem_port_arbiter: owner request dropped before grant");

  // A response outside ARB_WAIT (e.g. left over from before a reset) is ignored
  assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid |-> (state_q == ARB_WAIT))
    else $warning("mem_port_arbiter: mem_rvalid outside ARB_WAIT ignored");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DM_MAX_CONSEC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_be = 0; dm_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid} !== 4'b0) begin errors++; $display("FAIL reset_hs: got %b expected 0000", {if_gnt, if_rvalid, dm_gnt, dm_rvalid}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
    checks++; if (dut.drop_q !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", dut.drop_q); end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL single_if_gnt: got %b expected 1", if_gnt); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_mem_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL single_mem_addr: got %h expected 100", mem_addr); end
    checks++; if (dm_gnt !== 1'b0) begin errors++; $display("FAIL single_dm_gnt: got %b expected 0", dm_gnt); end
    step();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (if_rvalid !== 1'b1) begin errors++; $display("FAIL single_if_rvalid: got %b expected 1", if_rvalid); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_if_rdata: got %h expected deadbeef", if_rdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait: got %b expected 1", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_mem_req_wait: got %b expected 0", mem_req); end
    step();
    mem_rvalid = 0; mem_rdata = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b expected 0", busy); end
    step();
  endtask

  task automatic test_dm_priority();
    if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_be = 4'hF; dm_wdata = 32'h12345678;
    mem_gnt = 1;
    #1;
    checks++; if ({dm_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL prio_first_gnt: got dm/if %b expected 10", {dm_gnt, if_gnt}); end
    checks++; if ({mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h200, 4'hF, 32'h12345678}) begin errors++; $display("FAIL prio_dm_fields: got we=%b a=%h be=%h d=%h expected we=1 a=200 be=f d=12345678", mem_we, mem_addr, mem_be, mem_wdata); end
    step();
    dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rvalid = 1;
    #1;
    checks++; if ({dm_rvalid, if_rvalid, if_gnt, mem_req} !== 4'b1000) begin errors++; $display("FAIL prio_dm_rvalid: got dmrv/ifrv/ifgnt/req %b expected 1000", {dm_rvalid, if_rvalid, if_gnt, mem_req}); end
    step();
    mem_rvalid = 0; mem_gnt = 1;
    #1;
    checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0) begin errors++; $display("FAIL prio_if_second: got gnt=%b a=%h we=%b expected gnt=1 a=300 we=0", if_gnt, mem_addr, mem_we); end
    step();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL prio_if_rvalid: got rv=%b d=%h expected rv=1 d=cafe0001", if_rvalid, if_rdata); end
    step();
    clear_inputs();
    #1;
    checks++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL prio_cnt: got %0d expected 0", dut.cnt_q); end
    step();
  endtask

  task automatic test_fairness();
    logic exp_dm [6];
    exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    if_req = 1; if_addr = 32'h440; dm_req = 1; dm_addr = 32'h880; dm_be = 4'h3;
    for (int t = 0; t < 6; t++) begin
      mem_gnt = 1; mem_rvalid = 0;
      #1;
      checks++; if ({dm_gnt, if_gnt} !== {exp_dm[t], ~exp_dm[t]}) begin errors++; $display("FAIL fair_grant_%0d: got dm/if %b expected %b", t, {dm_gnt, if_gnt}, {exp_dm[t], ~exp_dm[t]}); end
      step();
      mem_gnt = 0; mem_rvalid = 1;
      if (t == 4) begin
        #1;
        checks++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL fair_cnt_after_if: got %0d expected 0", dut.cnt_q); end
      end
      step();
    end
    checks++; if (dut.cnt_q !== 3'd1) begin errors++; $display("FAIL fair_cnt_end: got %0d expected 1", dut.cnt_q); end
    clear_inputs();
    step();
  endtask

  task automatic test_gnt_stall();
    if_req = 1; if_addr = 32'h400;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin dm_req = 1; dm_addr = 32'h500; end
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || dm_gnt !== 1'b0) begin errors++; $display("FAIL stall_cycle_%0d: got req=%b a=%h dmgnt=%b expected req=1 a=400 dmgnt=0", c, mem_req, mem_addr, dm_gnt); end
      step();
    end
    mem_gnt = 1;
    #1;
    checks++; if ({if_gnt, dm_gnt} !== 2'b10 || mem_addr !== 32'h400) begin errors++; $display("FAIL stall_grant: got if/dm %b a=%h expected 10 a=400", {if_gnt, dm_gnt}, mem_addr); end
    step();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000A5A5;
    #1;
    checks++; if (if_rvalid !== 1'b1 || mem_req !== 1'b0 || dm_gnt !== 1'b0) begin errors++; $display("FAIL stall_resp: got ifrv=%b req=%b dmgnt=%b expected 1 0 0", if_rvalid, mem_req, dm_gnt); end
    step();
    mem_rvalid = 0; mem_gnt = 1;
    #1;
    checks++; if (dm_gnt !== 1'b1 || mem_addr !== 32'h500) begin errors++; $display("FAIL stall_dm_after: got gnt=%b a=%h expected 1 500", dm_gnt, mem_addr); end
    step();
    dm_req = 0; mem_gnt = 0; mem_rvalid = 1;
    #1;
    checks++; if (dm_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin errors++; $display("FAIL stall_dm_rvalid: got dm=%b if=%b expected 1 0", dm_rvalid, if_rvalid); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_flush();
    // flush while waiting for the response
    if_req = 1; if_addr = 32'h600; mem_gnt = 1;
    step();
    if_req = 0; mem_gnt = 0; if_flush = 1;
    #1;
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL flush_wait_rv0: got %b expected 0", if_rvalid); end
    step();
    if_flush = 0; mem_rvalid = 1; mem_rdata = 32'h11111111;
    #1;
    checks++; if (if_rvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_dropped: got rv=%b busy=%b expected 0 1", if_rvalid, busy); end
    step();
    mem_rvalid = 0;
    if_req = 1; if_addr = 32'h604; mem_gnt = 1;
    #1;
    checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h604) begin errors++; $display("FAIL flush_next_gnt: got gnt=%b a=%h expected 1 604", if_gnt, mem_addr); end
    step();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h22222222;
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h22222222) begin errors++; $display("FAIL flush_next_rv: got rv=%b d=%h expected 1 22222222", if_rvalid, if_rdata); end
    step();
    mem_rvalid = 0;
    // flush while the fetch is still waiting for its grant
    if_req = 1; if_addr = 32'h700;
    step();
    if_flush = 1;
    step();
    if_flush = 0; mem_gnt = 1;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_req_gnt: got %b expected 1", if_gnt); end
    step();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h33333333;
    #1;
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL flush_req_dropped: got %b expected 0", if_rvalid); end
    step();
    mem_rvalid = 0;
    #1;
    checks++; if (dut.drop_q !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_cleared: got drop=%b busy=%b expected 0 0", dut.drop_q, busy); end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    if_req = 1; if_addr = 32'h800; mem_gnt = 1;
    step();
    if_req = 0; mem_gnt = 0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_async: got %b expected 0", busy); end
    step();
    rst_n = 1;
    step();
    mem_rvalid = 1; mem_rdata = 32'h44444444;
    #1;
    checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin errors++; $display("FAIL rstmid_stale_rv: got if/dm %b expected 00", {if_rvalid, dm_rvalid}); end
    step();
    mem_rvalid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%b expected 0", busy); end
    if_req = 1; if_addr = 32'h900; mem_gnt = 1;
    #1;
    checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h900) begin errors++; $display("FAIL rstmid_recover: got gnt=%b a=%h expected 1 900", if_gnt, mem_addr); end
    step();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55555555;
    #1;
    checks++; if (if_rvalid !== 1'b1) begin errors++; $display("FAIL rstmid_recover_rv: got %b expected 1", if_rvalid); end
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_dm_priority();
    test_fairness();
    test_gnt_stall();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
